edge_map_reader: RTL

// Raster-scans the 1-bit edge map produced by edge detection and streams the
// (x,y) coordinate of every edge pixel to downstream corner/line fitting over a

---
 rtl/edge_map_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/edge_map_reader.sv
// Raster-scans a 1-bit edge map through a fixed-latency read port and streams
// the (x,y) of every set pixel over valid/ready, counting edges along the way.
module edge_map_reader #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        done_o,
    output logic        busy_o,
    output logic [18:0] read_addr_o,
    input  logic        read_data_i,
    output logic        pt_valid_o,
    input  logic        pt_ready_i,
    output logic [9:0]  pt_x_o,
    output logic [8:0]  pt_y_o,
    output logic [18:0] edge_count_o
);

    localparam int             WW          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WW-1:0]  WAIT_RELOAD = WW'(READ_LATENCY - 1);
    localparam logic [9:0]     X_LAST      = 10'(WIDTH - 1);
    localparam logic [8:0]     Y_LAST      = 9'(HEIGHT - 1);
    localparam logic [18:0]    COUNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [18:0]   read_addr_q, read_addr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          pt_valid_q, pt_valid_d;
    logic [9:0]    pt_x_q, pt_x_d;
    logic [8:0]    pt_y_q, pt_y_d;
    logic [18:0]   edge_count_q, edge_count_d;
    logic          advance;
    logic [9:0]    x_n;
    logic [8:0]    y_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            wait_q       <= '0;
            read_addr_q  <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            pt_valid_q   <= 1'b0;
            pt_x_q       <= '0;
            pt_y_q       <= '0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wait_q       <= wait_d;
            read_addr_q  <= read_addr_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            pt_valid_q   <= pt_valid_d;
            pt_x_q       <= pt_x_d;
            pt_y_q       <= pt_y_d;
            edge_count_q <= edge_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wait_d       = wait_q;
        read_addr_d  = read_addr_q;
        done_d       = 1'b0;
        busy_d       = busy_q;
        pt_valid_d   = pt_valid_q;
        pt_x_d       = pt_x_q;
        pt_y_d       = pt_y_q;
        edge_count_d = edge_count_q;
        advance      = 1'b0;
        x_n          = x_q;
        y_n          = y_q;

        // A start pulse overrides everything, including a pending handshake.
        if (start_i) begin
            state_d      = S_WAIT;
            x_d          = '0;
            y_d          = '0;
            wait_d       = WAIT_RELOAD;
            read_addr_d  = '0;
            busy_d       = 1'b1;
            pt_valid_d   = 1'b0;
            edge_count_d = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (wait_q == '0) begin
                        if (read_data_i) begin
                            pt_x_d     = x_q;
                            pt_y_d     = y_q;
                            pt_valid_d = 1'b1;
                            if (edge_count_q != COUNT_MAX) begin
                                edge_count_d = edge_count_q + 19'd1;
                            end
                            state_d = S_EMIT;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        wait_d = wait_q - WW'(1);
                    end
                end
                S_EMIT: begin
                    if (pt_ready_i) begin
                        pt_valid_d = 1'b0;
                        advance    = 1'b1;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (x_q == X_LAST) begin
                        x_n = '0;
                        y_n = y_q + 9'd1;
                    end else begin
                        x_n = x_q + 10'd1;
                    end
                    x_d         = x_n;
                    y_d         = y_n;
                    read_addr_d = {y_n, x_n};
                    wait_d      = WAIT_RELOAD;
                    state_d     = S_WAIT;
                end
            end
        end
    end

    always_comb begin
        done_o       = done_q;
        busy_o       = busy_q;
        read_addr_o  = read_addr_q;
        pt_valid_o   = pt_valid_q;
        pt_x_o       = pt_x_q;
        pt_y_o       = pt_y_q;
        edge_count_o = edge_count_q;
    end

endmodule
